// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with renderer latency alignment
//
// Divides clk down to a pixel tick, walks the horizontal/vertical raster
// counters, hands x/y to an external renderer and re-times blanking and
// sync so they line up with the colour that comes back RENDER_LAT clocks later.
//
// Ports:
//   clk, rst_n                        system clock, asynchronous active-low reset
//   x, y                              pixel coordinate to renderer (0 while blanked)
//   r, g, b                           renderer colour, valid RENDER_LAT clocks after x/y
//   vga_r, vga_g, vga_b               registered colour to DAC, forced to 0 in blanking
//   vga_hsync, vga_vsync              registered active-low syncs
//   de                                data enable, aligned with vga_r/g/b
//   frame_start                       one-clock pulse when counters wrap to (0,0)
module vga_timing_gen #(
   parameter int CLK_DIV    = 4,
   parameter int RENDER_LAT = 1,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] x,
   output logic [9:0] y,
   input  logic [7:0] r,
   input  logic [7:0] g,
   input  logic [7:0] b,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       vga_hsync,
   output logic       vga_vsync,
   output logic       de,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
   // Sync windows as [begin, end) ranges on the raw counters.
   localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div_cnt;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic             tick;
   logic             h_wrap;
   logic             v_wrap;

   assign tick   = (div_cnt == DIV_LAST);
   assign h_wrap = (h_cnt == H_LAST);
   assign v_wrap = (v_cnt == V_LAST);

   // frame_start is registered on the same edge that loads (0,0) into the
   // counters, so it is high exactly while they first read (0,0). Coming
   // out of reset the counters already sit at (0,0) without a wrap, so no
   // pulse is produced for that first frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt     <= '0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_start <= 1'b0;
      end else begin
         div_cnt     <= tick ? '0 : div_cnt + 1'b1;
         frame_start <= tick && h_wrap && v_wrap;
         if (tick) begin
            h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
            if (h_wrap) begin
               v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end
         end
      end
   end

   assign x = (h_cnt < H_ACT) ? h_cnt : 10'd0;
   assign y = (v_cnt < V_ACT) ? v_cnt : 10'd0;

   logic act_raw;
   logic hs_raw;
   logic vs_raw;

   assign act_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_raw  = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
   assign vs_raw  = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));

   // Timing flags travel through the same number of clocks as the renderer
   // takes, so the output register sees flags and colour for the same pixel.
   logic act_d;
   logic hs_d;
   logic vs_d;

   generate
      if (RENDER_LAT == 0) begin : g_direct
         assign act_d = act_raw;
         assign hs_d  = hs_raw;
         assign vs_d  = vs_raw;
      end else begin : g_delay
         logic [RENDER_LAT-1:0] act_sr;
         logic [RENDER_LAT-1:0] hs_sr;
         logic [RENDER_LAT-1:0] vs_sr;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               act_sr <= '0;
               hs_sr  <= '1;
               vs_sr  <= '1;
            end else begin
               act_sr <= (act_sr << 1) | RENDER_LAT'(act_raw);
               hs_sr  <= (hs_sr << 1) | RENDER_LAT'(hs_raw);
               vs_sr  <= (vs_sr << 1) | RENDER_LAT'(vs_raw);
            end
         end

         assign act_d = act_sr[RENDER_LAT-1];
         assign hs_d  = hs_sr[RENDER_LAT-1];
         assign vs_d  = vs_sr[RENDER_LAT-1];
      end
   endgenerate

   // Blanking wins over whatever the renderer drives outside the active area.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de        <= 1'b0;
         vga_hsync <= 1'b1;
         vga_vsync <= 1'b1;
         vga_r     <= 8'd0;
         vga_g     <= 8'd0;
         vga_b     <= 8'd0;
      end else begin
         de        <= act_d;
         vga_hsync <= hs_d;
         vga_vsync <= vs_d;
         vga_r     <= act_d ? r : 8'd0;
         vga_g     <= act_d ? g : 8'd0;
         vga_b     <= act_d ? b : 8'd0;
      end
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters: CLK_DIV, default 4, system clocks per pixel; RENDER_LAT, default 1, clock latency from x/y to rgb_in.
REQ-002 SHALL have parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33.
REQ-003 SHALL have ports, in this order:
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- x  output  10  pixel column to renderer, 0..639.
- y  output  10  pixel row to renderer, 0..479.
- r, g, b  input  8 each  renderer colour, valid RENDER_LAT clocks after x/y.
- vga_r, vga_g, vga_b  output  8 each  registered colour to DAC.
- vga_hsync, vga_vsync  output  1 each  active-low sync.
- de  output  1  data enable, aligned with vga_r/g/b.
- frame_start  output  1  one-clock pulse at start of frame.

Function
REQ-004 SHALL run a divider counter 0..CLK_DIV-1 and assert an internal pixel tick on the clock where the counter equals CLK_DIV-1; the counter then wraps to 0.
REQ-005 SHALL keep h_cnt 0..799 (H_TOTAL = sum of H params) and advance it only on the pixel tick, wrapping 799->0.
REQ-006 SHALL keep v_cnt 0..524 and advance it only on a tick where h_cnt wraps, wrapping 524->0.
REQ-007 SHALL drive x = h_cnt when h_cnt < H_ACTIVE, else 0; y = v_cnt when v_cnt < V_ACTIVE, else 0; x/y come directly from counter registers.
REQ-008 SHALL define raw active = (h_cnt < 640) and (v_cnt < 480).
REQ-009 SHALL define raw hsync low for h_cnt in 656..751 inclusive, and raw vsync low for v_cnt in 490..491 inclusive.
REQ-010 SHALL delay raw active, hsync and vsync through a RENDER_LAT-stage clock-rate shift register, so they align with r/g/b.
REQ-011 SHALL register outputs: de <= delayed active; vga_hsync/vsync <= delayed syncs; vga_r/g/b <= r/g/b when delayed active = 1, else 0.
REQ-012 Total latency SHALL be RENDER_LAT+1 clocks from a counter change to the matching vga_* change.
REQ-013 SHALL assert frame_start for exactly one clock: the clock on which counters first read (0,0) after wrapping from (799,524).
REQ-014 frame_start SHALL NOT assert on the first (0,0) after reset.
REQ-015 SHALL pass RENDER_LAT=0 as a direct path into the output register.
REQ-016 SHALL let blanking override input colour: nonzero r/g/b during blanking gives vga_r/g/b = 0.
REQ-017 SHALL, for CLK_DIV=1, tick on every clock.

Reset
REQ-018 On rst_n low, immediately and asynchronously: divider, h_cnt, v_cnt = 0; delay stages = inactive/sync-high.
REQ-019 On rst_n low, immediately and asynchronously: vga_r/g/b = 0, de = 0, vga_hsync = vga_vsync = 1, frame_start = 0.
REQ-020 Reset asserted mid-line or mid-frame SHALL abandon the frame; after release, counting SHALL restart at (0,0) with divider 0.
REQ-021 The first tick after release SHALL occur CLK_DIV clocks after the first active clock edge.

Verification
REQ-022 Line timing: reset release, CLK_DIV=4 -> hsync period 3200 clks, low 384 clks; first falling edge 656*4+RENDER_LAT+1 clks after counting starts.
REQ-023 Frame timing: run 2 frames -> vsync low 2 lines (6400 clks) per 1,680,000 clks; frame_start pulses exactly once per frame, never at the first (0,0).
REQ-024 Alignment: drive r = x[7:0], g = y[7:0] through a 1-clock registered model -> at de=1, vga_r matches delayed x; at pixel (639,479), vga_r = 0x7F, vga_g = 0xDF.
REQ-025 Blanking: hold r=g=b=0xFF constantly -> vga_* = 0 whenever de = 0; 640 de-high pixels per line, 480 such lines per frame.
REQ-026 Reset mid-frame: assert rst_n low at h=300, v=200 for 5 clks -> outputs at reset values immediately; after release x=y=0 and timing matches REQ-022.
REQ-027 Parameter sweep: CLK_DIV=1 and RENDER_LAT=0, and CLK_DIV=2 and RENDER_LAT=3 -> REQ-022..025 scaled checks pass.
